// File: rtl/booth_r4_seq_multiplier.sv
// Iterative radix-4 Booth multiplier: one recoded digit per cycle into a
// double-width accumulator, then an MSB-correction cycle for unsigned operands.
module booth_r4_seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sign,
  input  logic [WIDTH-1:0]     mulcand,
  input  logic [WIDTH-1:0]     mulplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int DIGITS = WIDTH / 2;
  localparam int CW     = $clog2(DIGITS) + 1;
  localparam int AW     = 2 * WIDTH + 2;
  localparam int PW     = WIDTH + 2;

  typedef enum logic [1:0] {IDLE, RUN, MSB, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand_q, mplier_q;
  logic             sign_q;
  logic [AW-1:0]    acc;

  logic             accept;
  logic             last_digit;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   mplier_ext;
  logic [2:0]       trip;
  logic [PW-1:0]    pp;
  logic [AW-1:0]    pp_shift;
  logic [AW-1:0]    corr;

  assign accept     = start && (state == IDLE || state == DONE);
  assign last_digit = (cnt == CW'(DIGITS - 1));
  assign busy       = (state == RUN) || (state == MSB);
  assign done       = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN:  if (last_digit) state_nxt = MSB;
      MSB:  state_nxt = DONE;
      DONE: state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Multiplicand widened by one bit so unsigned operands stay positive.
  assign m_ext      = {sign_q & mcand_q[WIDTH-1], mcand_q};
  assign mplier_ext = {mplier_q, 1'b0};
  assign trip       = 3'(mplier_ext >> {cnt, 1'b0});

  always_comb begin
    pp = '0;
    unique case (trip)
      3'b001, 3'b010: pp = {m_ext[WIDTH], m_ext};
      3'b011:         pp = {m_ext, 1'b0};
      3'b100:         pp = -{m_ext, 1'b0};
      3'b101, 3'b110: pp = -{m_ext[WIDTH], m_ext};
      default:        pp = '0;
    endcase
  end

  assign pp_shift = {{(AW-PW){pp[PW-1]}}, pp} << {cnt, 1'b0};

  // Recoding treats the multiplier as signed; unsigned mode adds back mcand<<WIDTH.
  assign corr = (!sign_q && mplier_q[WIDTH-1]) ? {2'b00, mcand_q, {WIDTH{1'b0}}} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      product  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
    end else if (accept) begin
      mcand_q  <= mulcand;
      mplier_q <= mulplier;
      sign_q   <= sign;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      unique case (state)
        RUN: begin
          acc <= acc + pp_shift;
          cnt <= cnt + 1'b1;
        end
        MSB:     product <= (2*WIDTH)'(acc + corr);
        default: ;
      endcase
    end
  end
endmodule
